// File: rtl/tripwire_pkg.sv
// Shared types and default beam-window constants for the tripwire controller.
package tripwire_pkg;

  typedef enum logic [2:0] {
    DISARMED = 3'd0,
    ARMING   = 3'd1,
    ARMED    = 3'd2,
    ENTRY    = 3'd3,
    ALARM    = 3'd4
  } state_t;

  localparam int unsigned BEAM_LO_DEF = 4000;
  localparam int unsigned BEAM_HI_DEF = 4999;

endpackage

// File: rtl/tripwire_controller_beam_debouncer.sv
// Beam window qualifier and break debouncer; beam_broken rises on the same edge that
// brk_cnt reaches DEBOUNCE.
module beam_debouncer
  import tripwire_pkg::*;
#(
  parameter int unsigned BEAM_LO  = BEAM_LO_DEF,
  parameter int unsigned BEAM_HI  = BEAM_HI_DEF,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] light_sensor,
  input  logic        sample_valid,
  output logic        beam_broken
);

  localparam int unsigned CW   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
  localparam logic [12:0] LO   = 13'(BEAM_LO);
  localparam logic [12:0] HI   = 13'(BEAM_HI);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE);

  logic [CW-1:0] brk_cnt;
  logic [CW-1:0] cnt_next;
  logic          in_window;

  assign in_window = (light_sensor >= LO) && (light_sensor <= HI);

  always_comb begin
    cnt_next = brk_cnt;
    if (brk_cnt != CMAX) cnt_next = brk_cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brk_cnt     <= '0;
      beam_broken <= 1'b0;
    end else if (sample_valid) begin
      if (in_window) begin
        brk_cnt     <= '0;
        beam_broken <= 1'b0;
      end else begin
        brk_cnt     <= cnt_next;
        beam_broken <= (cnt_next == CMAX);
      end
    end
  end

endmodule

// File: rtl/tripwire_controller.sv
// Tripwire arm/disarm sequencer: exit delay, entry grace, alarm, trip counting.
// Optional feature macro: TRIPWIRE_AUTO_REARM_EN (timed alarm with automatic re-arm).
module tripwire_controller
  import tripwire_pkg::*;
#(
  parameter int unsigned BEAM_LO   = BEAM_LO_DEF,
  parameter int unsigned BEAM_HI   = BEAM_HI_DEF,
  parameter int unsigned DEBOUNCE  = 4,
  parameter int unsigned EXIT_CYC  = 50_000_000,
  parameter int unsigned ENTRY_CYC = 25_000_000,
  parameter int unsigned ALARM_CYC = 250_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] light_sensor,
  input  logic        sample_valid,
  input  logic        arm,
  input  logic        disarm,
  output logic        armed,
  output logic        alarm,
  output logic        beam_broken,
  output logic        arm_fail,
  output logic [7:0]  trip_count,
  output logic [2:0]  state_o
);

  localparam int unsigned TMAX_EE = (EXIT_CYC > ENTRY_CYC) ? EXIT_CYC : ENTRY_CYC;
  localparam int unsigned TMAX    = (TMAX_EE > ALARM_CYC) ? TMAX_EE : ALARM_CYC;
  localparam int unsigned TW      = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] EXIT_LAST  = TW'(EXIT_CYC - 1);
  localparam logic [TW-1:0] ENTRY_LAST = TW'(ENTRY_CYC - 1);
`ifdef TRIPWIRE_AUTO_REARM_EN
  localparam logic [TW-1:0] ALARM_LAST = TW'(ALARM_CYC - 1);
`endif

  state_t        state, state_next;
  logic [TW-1:0] timer;
  logic          timer_clr, timer_inc;
  logic          fail_next, trip;
  logic          brk_d;
  logic          brk_rise;

  beam_debouncer #(
    .BEAM_LO  (BEAM_LO),
    .BEAM_HI  (BEAM_HI),
    .DEBOUNCE (DEBOUNCE)
  ) u_debouncer (
    .clk          (clk),
    .rst_n        (rst_n),
    .light_sensor (light_sensor),
    .sample_valid (sample_valid),
    .beam_broken  (beam_broken)
  );

  assign brk_rise = beam_broken & ~brk_d;
  assign state_o  = state;

  always_comb begin
    state_next = state;
    timer_clr  = 1'b0;
    timer_inc  = 1'b0;
    fail_next  = 1'b0;
    trip       = 1'b0;
    case (state)
      DISARMED: if (arm) state_next = ARMING;
      ARMING: begin
        if (timer == EXIT_LAST) begin
          if (!beam_broken) begin
            state_next = ARMED;
          end else begin
            state_next = DISARMED;
            fail_next  = 1'b1;
          end
        end else begin
          timer_inc = 1'b1;
        end
      end
      ARMED: begin
        if (brk_rise) begin
          state_next = ENTRY;
          trip       = 1'b1;
        end
      end
      ENTRY: begin
        if (timer == ENTRY_LAST) state_next = ALARM;
        else timer_inc = 1'b1;
      end
      ALARM: begin
`ifdef TRIPWIRE_AUTO_REARM_EN
        // Timer parks at its last value while the beam stays broken.
        if (timer == ALARM_LAST) begin
          if (!beam_broken) state_next = ARMED;
        end else begin
          timer_inc = 1'b1;
        end
`endif
      end
      default: state_next = DISARMED;
    endcase

    if (disarm) begin
      state_next = DISARMED;
      fail_next  = 1'b0;
      trip       = 1'b0;
      timer_clr  = 1'b1;
    end
    if (state_next != state) timer_clr = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= DISARMED;
      timer      <= '0;
      armed      <= 1'b0;
      alarm      <= 1'b0;
      arm_fail   <= 1'b0;
      trip_count <= '0;
      brk_d      <= 1'b0;
    end else begin
      state    <= state_next;
      armed    <= (state_next == ARMED) || (state_next == ENTRY) || (state_next == ALARM);
      alarm    <= (state_next == ALARM);
      arm_fail <= fail_next;
      brk_d    <= beam_broken;
      if (timer_clr)      timer <= '0;
      else if (timer_inc) timer <= timer + TW'(1);
      if (trip && (trip_count != '1)) trip_count <= trip_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_tripwire_controller.sv
// Directed self-checking bench for tripwire_controller (EXIT=10, ENTRY=5, ALARM=8, DEBOUNCE=4).
module tb_tripwire_controller;
  import tripwire_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] light_sensor;
  logic        sample_valid;
  logic        arm;
  logic        disarm;
  logic        armed;
  logic        alarm;
  logic        beam_broken;
  logic        arm_fail;
  logic [7:0]  trip_count;
  logic [2:0]  state_o;

  int checks = 0;
  int errors = 0;
  int exp_trips = 0;

  tripwire_controller #(
    .EXIT_CYC  (10),
    .ENTRY_CYC (5),
    .ALARM_CYC (8),
    .DEBOUNCE  (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .light_sensor (light_sensor),
    .sample_valid (sample_valid),
    .arm          (arm),
    .disarm       (disarm),
    .armed        (armed),
    .alarm        (alarm),
    .beam_broken  (beam_broken),
    .arm_fail     (arm_fail),
    .trip_count   (trip_count),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  // Advance one active edge; outputs are examined 1 time unit after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [12:0] v);
    light_sensor = v;
    sample_valid = 1'b1;
    cyc();
    sample_valid = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    cyc();
    arm = 1'b0;
  endtask

  task automatic pulse_disarm();
    disarm = 1'b1;
    cyc();
    disarm = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; light_sensor = '0; sample_valid = 1'b0; arm = 1'b0; disarm = 1'b0;
    cyc();
    cyc();
    checks++;
    if ({armed, alarm, beam_broken, arm_fail, trip_count, state_o} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=0", {armed, alarm, beam_broken, arm_fail, trip_count, state_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_arm();
    int bad = 0;
    for (int i = 0; i < 10; i++) sample(13'd4500);
    pulse_arm();
    checks++;
    if (state_o !== 3'(ARMING)) begin
      errors++; $display("FAIL arm_enter_arming got=%0d want=%0d", state_o, ARMING);
    end
    for (int i = 0; i < 9; i++) begin
      cyc();
      if (state_o !== 3'(ARMING) || armed !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL arm_stay_arming got=%0d bad cycles want=0", bad);
    end
    cyc();
    checks++;
    if (state_o !== 3'(ARMED) || armed !== 1'b1 || alarm !== 1'b0) begin
      errors++;
      $display("FAIL arm_reach_armed got state=%0d armed=%b alarm=%b want state=%0d armed=1 alarm=0",
               state_o, armed, alarm, ARMED);
    end
  endtask

  task automatic test_no_trip();
    for (int i = 0; i < 3; i++) sample(13'd3999);
    sample(13'd4500);
    cyc();
    checks++;
    if (state_o !== 3'(ARMED) || trip_count !== 8'd0 || beam_broken !== 1'b0) begin
      errors++;
      $display("FAIL no_trip got state=%0d trips=%0d brk=%b want state=%0d trips=0 brk=0",
               state_o, trip_count, beam_broken, ARMED);
    end
  endtask

  task automatic test_trip();
    int bad = 0;
    for (int i = 0; i < 3; i++) sample(13'd5000);
    checks++;
    if (beam_broken !== 1'b0) begin
      errors++; $display("FAIL trip_debounce_3 got=%b want=0", beam_broken);
    end
    sample(13'd5000);
    checks++;
    if (beam_broken !== 1'b1 || state_o !== 3'(ARMED)) begin
      errors++; $display("FAIL trip_debounce_4 got brk=%b state=%0d want brk=1 state=%0d", beam_broken, state_o, ARMED);
    end
    cyc();
    exp_trips++;
    checks++;
    if (state_o !== 3'(ENTRY) || trip_count !== 8'(exp_trips)) begin
      errors++;
      $display("FAIL trip_entry got state=%0d trips=%0d want state=%0d trips=%0d", state_o, trip_count, ENTRY, exp_trips);
    end
    // restoring the beam mid-entry must not cancel it
    sample(13'd4500);
    if (state_o !== 3'(ENTRY) || alarm !== 1'b0) bad++;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (state_o !== 3'(ENTRY) || alarm !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL trip_entry_hold got=%0d bad cycles want=0", bad);
    end
    cyc();
    checks++;
    if (state_o !== 3'(ALARM) || alarm !== 1'b1 || armed !== 1'b1) begin
      errors++;
      $display("FAIL trip_alarm got state=%0d alarm=%b armed=%b want state=%0d alarm=1 armed=1", state_o, alarm, armed, ALARM);
    end
  endtask

  task automatic test_alarm_hold();
`ifdef TRIPWIRE_AUTO_REARM_EN
    for (int i = 0; i < 7; i++) cyc();
    checks++;
    if (state_o !== 3'(ALARM) || alarm !== 1'b1) begin
      errors++; $display("FAIL rearm_alarm_len got state=%0d alarm=%b want state=%0d alarm=1", state_o, alarm, ALARM);
    end
    cyc();
    checks++;
    if (state_o !== 3'(ARMED) || alarm !== 1'b0 || armed !== 1'b1) begin
      errors++; $display("FAIL rearm_armed got state=%0d alarm=%b want state=%0d alarm=0", state_o, alarm, ARMED);
    end
    for (int i = 0; i < 4; i++) sample(13'd5000);
    cyc();
    exp_trips++;
    for (int i = 0; i < 5; i++) cyc();
    for (int i = 0; i < 20; i++) cyc();
    checks++;
    if (state_o !== 3'(ALARM) || trip_count !== 8'(exp_trips)) begin
      errors++;
      $display("FAIL rearm_broken_hold got state=%0d trips=%0d want state=%0d trips=%0d", state_o, trip_count, ALARM, exp_trips);
    end
`else
    int bad = 0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (state_o !== 3'(ALARM) || alarm !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL alarm_latch got=%0d bad cycles want=0", bad);
    end
`endif
  endtask

  task automatic test_disarm_wins();
    arm = 1'b1;
    disarm = 1'b1;
    cyc();
    arm = 1'b0;
    disarm = 1'b0;
    checks++;
    if (state_o !== 3'(DISARMED) || alarm !== 1'b0 || armed !== 1'b0) begin
      errors++;
      $display("FAIL disarm_wins got state=%0d alarm=%b armed=%b want state=0 alarm=0 armed=0", state_o, alarm, armed);
    end
  endtask

  task automatic test_arm_fail();
    sample(13'd4500);
    pulse_arm();
    for (int i = 0; i < 4; i++) sample(13'd0);
    for (int i = 0; i < 5; i++) cyc();
    checks++;
    if (state_o !== 3'(ARMING) || arm_fail !== 1'b0 || beam_broken !== 1'b1) begin
      errors++;
      $display("FAIL arm_fail_pre got state=%0d fail=%b brk=%b want state=%0d fail=0 brk=1", state_o, arm_fail, beam_broken, ARMING);
    end
    cyc();
    checks++;
    if (state_o !== 3'(DISARMED) || arm_fail !== 1'b1) begin
      errors++; $display("FAIL arm_fail_pulse got state=%0d fail=%b want state=0 fail=1", state_o, arm_fail);
    end
    cyc();
    checks++;
    if (arm_fail !== 1'b0 || state_o !== 3'(DISARMED)) begin
      errors++; $display("FAIL arm_fail_width got fail=%b state=%0d want fail=0 state=0", arm_fail, state_o);
    end
  endtask

  task automatic test_async_reset();
    sample(13'd4500);
    pulse_arm();
    for (int i = 0; i < 10; i++) cyc();
    for (int i = 0; i < 4; i++) sample(13'd5000);
    cyc();
    exp_trips++;
    checks++;
    if (state_o !== 3'(ENTRY) || trip_count !== 8'(exp_trips)) begin
      errors++;
      $display("FAIL async_pre got state=%0d trips=%0d want state=%0d trips=%0d", state_o, trip_count, ENTRY, exp_trips);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({armed, alarm, beam_broken, arm_fail, trip_count, state_o} !== 14'd0) begin
      errors++;
      $display("FAIL async_reset got=%b want=0", {armed, alarm, beam_broken, arm_fail, trip_count, state_o});
    end
    exp_trips = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_saturation();
    int bad = 0;
    for (int n = 0; n < 260; n++) begin
      sample(13'd4500);
      pulse_arm();
      for (int i = 0; i < 10; i++) cyc();
      for (int i = 0; i < 4; i++) sample(13'd5000);
      cyc();
      if (exp_trips < 255) exp_trips++;
      if (trip_count !== 8'(exp_trips) || state_o !== 3'(ENTRY)) bad++;
      pulse_disarm();
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL sat_sequence got=%0d bad iterations want=0", bad);
    end
    checks++;
    if (trip_count !== 8'd255) begin
      errors++; $display("FAIL sat_final got=%0d want=255", trip_count);
    end
  endtask

  initial begin
    test_reset();
    test_arm();
    test_no_trip();
    test_trip();
    test_alarm_hold();
    test_disarm_wins();
    test_arm_fail();
    test_async_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
